// File: rtl/proc_pkg.sv
// Shared Project3 processor definitions: register width,
// opcodes, scoreboard slot type and operand-use decode.
package proc_pkg;

    localparam int REGNOBITS = 4;

    localparam logic [3:0] OP1_ALUR  = 4'b0000;
    localparam logic [3:0] OP1_ALUI  = 4'b1000;
    localparam logic [3:0] OP1_CMPR  = 4'b0010;
    localparam logic [3:0] OP1_CMPI  = 4'b1010;
    localparam logic [3:0] OP1_BCOND = 4'b0110;
    localparam logic [3:0] OP1_SW    = 4'b0101;
    localparam logic [3:0] OP1_LW    = 4'b1001;
    localparam logic [3:0] OP1_JAL   = 4'b1011;

    // One bit per opcode: set where the instruction reads that operand.
    localparam logic [15:0] USESRS_MASK =
        (16'h1 << OP1_ALUR) | (16'h1 << OP1_ALUI) |
        (16'h1 << OP1_CMPR) | (16'h1 << OP1_CMPI) |
        (16'h1 << OP1_BCOND) | (16'h1 << OP1_SW) |
        (16'h1 << OP1_LW) | (16'h1 << OP1_JAL);

    localparam logic [15:0] USESRT_MASK =
        (16'h1 << OP1_ALUR) | (16'h1 << OP1_CMPR) |
        (16'h1 << OP1_BCOND) | (16'h1 << OP1_SW);

    typedef struct packed {
        logic                 valid;
        logic [REGNOBITS-1:0] regno;
    } sb_slot_t;

    function automatic logic op_uses_rs(input logic [3:0] op1);
        return USESRS_MASK[op1];
    endfunction

    function automatic logic op_uses_rt(input logic [3:0] op1);
        return USESRT_MASK[op1];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Count up on inc, stick at all-ones, clear on request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// F/D/A/M hazard and redirect controller: RAW stall via a
// two-slot write scoreboard, mispredict squash, perf counters.
module hazard_ctrl
    import proc_pkg::*;
#(
    parameter int CNTBITS = 16,
    parameter int NSLOTS  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_D,
    input  logic [REGNOBITS-1:0] rs_D,
    input  logic [REGNOBITS-1:0] rt_D,
    input  logic                 usesrs_D,
    input  logic                 usesrt_D,
    input  logic                 wrreg_D,
    input  logic [REGNOBITS-1:0] wregno_D,
    input  logic                 mispred_A,
    output logic                 stall_F,
    output logic                 flush_D,
    output logic                 busy_A,
    output logic                 busy_M,
    output logic [CNTBITS-1:0]   stallcnt,
    output logic [CNTBITS-1:0]   flushcnt,
    input  logic                 cntclr
);

    if (NSLOTS != 2) begin : g_bad_nslots
        $error("hazard_ctrl: NSLOTS must be 2");
    end

    sb_slot_t slot_a;
    sb_slot_t slot_m;
    logic     hit_s;
    logic     hit_t;
    logic     haz;

    // Compare D sources against both older in-flight writers.
    always_comb begin
        hit_s = 1'b0;
        hit_t = 1'b0;
        haz   = 1'b0;
        hit_s = usesrs_D &
            ((slot_a.valid & (slot_a.regno == rs_D)) |
             (slot_m.valid & (slot_m.regno == rs_D)));
        hit_t = usesrt_D &
            ((slot_a.valid & (slot_a.regno == rt_D)) |
             (slot_m.valid & (slot_m.regno == rt_D)));
        haz = valid_D & (hit_s | hit_t);
    end

    // Mispredict beats hazard; reset forces a bubble with no stall.
    always_comb begin
        stall_F = 1'b0;
        flush_D = 1'b0;
        if (!reset_n) begin
            flush_D = 1'b1;
        end else if (mispred_A) begin
            flush_D = 1'b1;
        end else if (haz) begin
            stall_F = 1'b1;
            flush_D = 1'b1;
        end
    end

    // Advance the scoreboard: A moves to M, D (or a bubble) into A.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_a <= '0;
            slot_m <= '0;
        end else begin
            slot_m       <= slot_a;
            slot_a.valid <= valid_D & wrreg_D & ~flush_D;
            slot_a.regno <= wregno_D;
        end
    end

    assign busy_A = slot_a.valid;
    assign busy_M = slot_m.valid;

    sat_counter #(.W(CNTBITS)) u_stallcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_F),
        .clr     (cntclr),
        .q       (stallcnt)
    );

    sat_counter #(.W(CNTBITS)) u_flushcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (mispred_A),
        .clr     (cntclr),
        .q       (flushcnt)
    );

endmodule
